// File: rtl/shifter_operand_pipe.sv
// ARM-style shifter-operand / address-offset generator.
// Two-stage valid/ready pipeline: S1 captures the request, S2 holds the
// decoded operand, carry-out and unsupported-encoding flag.
module shifter_operand_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ir,
  input  logic [WIDTH-1:0] rm,
  input  logic [WIDTH-1:0] rs,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             shift_cout,
  output logic             err
);

  localparam logic [7:0] WIDTH_AMT = 8'(WIDTH);

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  // Core barrel shift for amounts >= 1; returns {carry, value}.
  // Shifting a (WIDTH+1)-bit vector lets the carry fall out naturally and
  // makes oversized amounts saturate to zero / sign without extra compares.
  function automatic logic [WIDTH:0] shift_core(input shift_e typ,
                                                input logic [7:0] amt,
                                                input logic [WIDTH-1:0] val);
    logic [WIDTH:0]     ext;
    logic [2*WIDTH-1:0] dbl;
    logic [7:0]         r;
    logic [WIDTH:0]     res;
    ext = '0;
    dbl = '0;
    r   = amt & (WIDTH_AMT - 8'd1);
    res = '0;
    case (typ)
      SH_LSL: begin
        ext = {1'b0, val} << amt;
        res = ext;
      end
      SH_LSR: begin
        ext = {val, 1'b0} >> amt;
        res = {ext[0], ext[WIDTH:1]};
      end
      SH_ASR: begin
        ext = $signed({val, 1'b0}) >>> amt;
        res = {ext[0], ext[WIDTH:1]};
      end
      SH_ROR: begin
        // Rotation by r (mod WIDTH); carry is always the new MSB, which
        // also covers r == 0 (carry = rm[WIDTH-1]).
        dbl = {val, val} >> r;
        res = {dbl[WIDTH-1], dbl[WIDTH-1:0]};
      end
      default: res = {1'b0, val};
    endcase
    return res;
  endfunction

  // Immediate-amount shift: amount 0 encodes LSL #0, LSR/ASR #WIDTH, RRX.
  function automatic logic [WIDTH:0] imm_shift(input shift_e typ,
                                               input logic [4:0] n,
                                               input logic [WIDTH-1:0] val,
                                               input logic cin);
    logic [WIDTH:0] res;
    res = {cin, val};
    if (n == 5'd0) begin
      case (typ)
        SH_LSL:  res = {cin, val};
        SH_LSR:  res = shift_core(typ, WIDTH_AMT, val);
        SH_ASR:  res = shift_core(typ, WIDTH_AMT, val);
        SH_ROR:  res = {val[0], cin, val[WIDTH-1:1]};
        default: res = {cin, val};
      endcase
    end else begin
      res = shift_core(typ, {3'b000, n}, val);
    end
    return res;
  endfunction

  // Register-amount shift: a zero amount passes rm and the incoming carry.
  function automatic logic [WIDTH:0] reg_shift(input shift_e typ,
                                               input logic [7:0] a,
                                               input logic [WIDTH-1:0] val,
                                               input logic cin);
    logic [WIDTH:0] res;
    if (a == 8'd0) begin
      res = {cin, val};
    end else begin
      res = shift_core(typ, a, val);
    end
    return res;
  endfunction

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      ir_q, ir_d;
  logic [WIDTH-1:0] rm_q, rm_d;
  logic [7:0]       rs_q, rs_d;
  logic             cin_q, cin_d;

  // Stage 2 state
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  // Handshake / decode
  logic             s2_adv_s;
  logic [WIDTH:0]   res_s;
  logic             err_s;
  logic [WIDTH:0]   imm_rot_s;
  logic             rs_unused_s;
  logic             ir_unused_s;

  // Only the low byte of rs and the mode/operand fields of ir matter.
  assign rs_unused_s = ^rs[WIDTH-1:8];
  assign ir_unused_s = ^{ir_q[31:28], ir_q[24]};

  // Pipeline handshake: S2 moves when empty or drained; S1 follows S2.
  always_comb begin
    s2_adv_s = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_adv_s;
  end

  // S1 next-state: capture a new request whenever S1 may advance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    ir_d       = ir_q;
    rm_d       = rm_q;
    rs_d       = rs_q;
    cin_d      = cin_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        ir_d  = ir;
        rm_d  = rm;
        rs_d  = rs[7:0];
        cin_d = c_in;
      end else begin
        ir_d  = ir_q;
        rm_d  = rm_q;
        rs_d  = rs_q;
        cin_d = cin_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Operand decode of the request held in S1.
  always_comb begin
    res_s     = {cin_q, rm_q};
    err_s     = 1'b0;
    imm_rot_s = shift_core(SH_ROR, {3'b000, ir_q[11:8], 1'b0},
                           {{(WIDTH-8){1'b0}}, ir_q[7:0]});
    case (ir_q[27:25])
      3'b000: begin
        if (!ir_q[4]) begin
          res_s = imm_shift(shift_e'(ir_q[6:5]), ir_q[11:7], rm_q, cin_q);
        end else if (!ir_q[7]) begin
          res_s = reg_shift(shift_e'(ir_q[6:5]), rs_q, rm_q, cin_q);
        end else begin
          res_s = {cin_q, rm_q};
          err_s = 1'b1;
        end
      end
      3'b001: begin
        if (ir_q[11:8] == 4'd0) begin
          res_s = {cin_q, imm_rot_s[WIDTH-1:0]};
        end else begin
          res_s = {imm_rot_s[WIDTH-1], imm_rot_s[WIDTH-1:0]};
        end
      end
      3'b010: begin
        res_s = {cin_q, {(WIDTH-12){1'b0}}, ir_q[11:0]};
      end
      3'b011: begin
        if (!ir_q[4]) begin
          res_s = imm_shift(shift_e'(ir_q[6:5]), ir_q[11:7], rm_q, cin_q);
        end else begin
          res_s = {cin_q, rm_q};
          err_s = 1'b1;
        end
      end
      3'b101: begin
        res_s = {cin_q, {(WIDTH-26){ir_q[23]}}, ir_q[23:0], 2'b00};
      end
      default: begin
        res_s = {cin_q, rm_q};
        err_s = 1'b0;
      end
    endcase
  end

  // S2 next-state: load the decoded result on advance, hold while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    cout_d      = cout_q;
    err_d       = err_q;
    if (s2_adv_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d  = res_s[WIDTH-1:0];
        cout_d = res_s[WIDTH];
        err_d  = err_s;
      end else begin
        out_d  = out_q;
        cout_d = cout_q;
        err_d  = err_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // S1 registers; reset discards any captured request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      ir_q       <= 32'd0;
      rm_q       <= '0;
      rs_q       <= 8'd0;
      cin_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      ir_q       <= ir_d;
      rm_q       <= rm_d;
      rs_q       <= rs_d;
      cin_q      <= cin_d;
    end
  end

  // S2 registers; reset drops the pending result and clears the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      cout_q      <= cout_d;
      err_q       <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out        = out_q;
  assign shift_cout = cout_q;
  assign err        = err_q;

endmodule

// File: tb/tb_shifter_operand_pipe.sv
// Directed bench for shifter_operand_pipe: a 32-bit instance for the shift,
// decode and flow-control scenarios plus a 64-bit instance for branch offsets.
module tb_shifter_operand_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, c_in, out_valid, out_ready, shift_cout, err;
  logic [31:0] ir, rm, rs, out;

  logic        in_valid_w, in_ready_w, c_in_w, out_valid_w, out_ready_w, shift_cout_w, err_w;
  logic [31:0] ir_w;
  logic [63:0] rm_w, rs_w, out_w;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic [31:0] rm;
    logic [31:0] rs;
    logic        cin;
    logic [31:0] eo;
    logic        ec;
    logic        ee;
  } vec_t;

  shifter_operand_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ir(ir), .rm(rm), .rs(rs), .c_in(c_in), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .shift_cout(shift_cout), .err(err)
  );

  shifter_operand_pipe #(.WIDTH(64)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .ir(ir_w), .rm(rm_w), .rs(rs_w), .c_in(c_in_w), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .out(out_w), .shift_cout(shift_cout_w), .err(err_w)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string n, input logic [31:0] i_ir, input logic [31:0] i_rm,
                              input logic [31:0] i_rs, input logic i_cin, input logic [31:0] eo,
                              input logic ec, input logic ee);
    vec_t v;
    v.name = n; v.ir = i_ir; v.rm = i_rm; v.rs = i_rs; v.cin = i_cin;
    v.eo = eo; v.ec = ec; v.ee = ee;
    return v;
  endfunction

  // Drive one request into an idle pipe and wait (bounded) for its result.
  task automatic run32(input logic [31:0] i_ir, input logic [31:0] i_rm, input logic [31:0] i_rs,
                       input logic i_cin, output logic [31:0] o_out, output logic o_c,
                       output logic o_err, output int o_lat);
    @(negedge clk);
    ir = i_ir; rm = i_rm; rs = i_rs; c_in = i_cin; out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    o_lat = 0; o_out = 32'd0; o_c = 1'b0; o_err = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (out_valid) begin
        o_out = out; o_c = shift_cout; o_err = err; o_lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out !== 32'd0) begin errors++; $display("FAIL reset_out got %h want 0", out); end
    checks++; if ({shift_cout, err} !== 2'b00) begin errors++; $display("FAIL reset_cout_err got %b want 00", {shift_cout, err}); end
    checks++; if (out_valid_w !== 1'b0) begin errors++; $display("FAIL reset_out_valid_w got %b want 0", out_valid_w); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_latency();
    logic [31:0] o; logic c, e; int lat;
    run32(32'hE1A00080, 32'h80000001, 32'd0, 1'b0, o, c, e, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL latency got %0d want 2", lat); end
    checks++; if (o !== 32'h00000002) begin errors++; $display("FAIL lsl1_out got %h want 00000002", o); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL lsl1_cout got %b want 1", c); end
  endtask

  task automatic test_imm_shift();
    vec_t q[$]; logic [31:0] o; logic c, e; int lat;
    q.push_back(mk("lsl0",   32'hE1A00000, 32'h12345678, 32'd0, 1'b1, 32'h12345678, 1'b1, 1'b0));
    q.push_back(mk("lsr32",  32'hE1A00020, 32'h80000000, 32'd0, 1'b0, 32'h00000000, 1'b1, 1'b0));
    q.push_back(mk("lsr4",   32'hE1A00220, 32'h0000001F, 32'd0, 1'b0, 32'h00000001, 1'b1, 1'b0));
    q.push_back(mk("asr32",  32'hE1A00040, 32'h80000000, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0));
    q.push_back(mk("asr8",   32'hE1A00440, 32'h80000080, 32'd0, 1'b0, 32'hFF800000, 1'b1, 1'b0));
    q.push_back(mk("rrx",    32'hE1A00060, 32'h00000003, 32'd0, 1'b1, 32'h80000001, 1'b1, 1'b0));
    q.push_back(mk("ror8",   32'hE1A00460, 32'h12345678, 32'd0, 1'b1, 32'h78123456, 1'b0, 1'b0));
    foreach (q[i]) begin
      run32(q[i].ir, q[i].rm, q[i].rs, q[i].cin, o, c, e, lat);
      checks++;
      if (lat == 0) begin
        errors++; $display("FAIL %s timeout waiting for out_valid", q[i].name);
      end else begin
        checks++; if (o !== q[i].eo) begin errors++; $display("FAIL %s out got %h want %h", q[i].name, o, q[i].eo); end
        checks++; if (c !== q[i].ec) begin errors++; $display("FAIL %s cout got %b want %b", q[i].name, c, q[i].ec); end
        checks++; if (e !== q[i].ee) begin errors++; $display("FAIL %s err got %b want %b", q[i].name, e, q[i].ee); end
      end
    end
  endtask

  task automatic test_reg_shift();
    vec_t q[$]; logic [31:0] o; logic c, e; int lat;
    q.push_back(mk("rlsr32", 32'hE1A00130, 32'h80000000, 32'd32, 1'b0, 32'h00000000, 1'b1, 1'b0));
    q.push_back(mk("rlsr33", 32'hE1A00130, 32'h80000000, 32'd33, 1'b1, 32'h00000000, 1'b0, 1'b0));
    q.push_back(mk("rlsr0",  32'hE1A00130, 32'h80000000, 32'd0,  1'b1, 32'h80000000, 1'b1, 1'b0));
    q.push_back(mk("rlsl32", 32'hE1A00110, 32'h00000001, 32'd32, 1'b0, 32'h00000000, 1'b1, 1'b0));
    q.push_back(mk("rlsl4",  32'hE1A00110, 32'h1000000F, 32'h104, 1'b0, 32'h000000F0, 1'b1, 1'b0));
    q.push_back(mk("rasr40", 32'hE1A00150, 32'h80000000, 32'd40, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0));
    q.push_back(mk("rror32", 32'hE1A00170, 32'h80000001, 32'd32, 1'b0, 32'h80000001, 1'b1, 1'b0));
    q.push_back(mk("rror36", 32'hE1A00170, 32'h0000000F, 32'd36, 1'b0, 32'hF0000000, 1'b1, 1'b0));
    q.push_back(mk("regerr", 32'hE1A00090, 32'h00000055, 32'd3,  1'b0, 32'h00000055, 1'b0, 1'b1));
    foreach (q[i]) begin
      run32(q[i].ir, q[i].rm, q[i].rs, q[i].cin, o, c, e, lat);
      checks++;
      if (lat == 0) begin
        errors++; $display("FAIL %s timeout waiting for out_valid", q[i].name);
      end else begin
        checks++; if (o !== q[i].eo) begin errors++; $display("FAIL %s out got %h want %h", q[i].name, o, q[i].eo); end
        checks++; if (c !== q[i].ec) begin errors++; $display("FAIL %s cout got %b want %b", q[i].name, c, q[i].ec); end
        checks++; if (e !== q[i].ee) begin errors++; $display("FAIL %s err got %b want %b", q[i].name, e, q[i].ee); end
      end
    end
  endtask

  task automatic test_modes();
    vec_t q[$]; logic [31:0] o; logic c, e; int lat;
    q.push_back(mk("rotimm4", 32'hE3A004FF, 32'h12345678, 32'd0, 1'b0, 32'hFF000000, 1'b1, 1'b0));
    q.push_back(mk("rotimm0", 32'hE3A000AB, 32'h12345678, 32'd0, 1'b0, 32'h000000AB, 1'b0, 1'b0));
    q.push_back(mk("ldsimm",  32'hE5900ABC, 32'h12345678, 32'd0, 1'b1, 32'h00000ABC, 1'b1, 1'b0));
    q.push_back(mk("ldsreg",  32'hE7900100, 32'h40000001, 32'd0, 1'b0, 32'h00000004, 1'b1, 1'b0));
    q.push_back(mk("ldsrerr", 32'hE7900010, 32'h0000ABCD, 32'd0, 1'b1, 32'h0000ABCD, 1'b1, 1'b1));
    q.push_back(mk("bpos",    32'hEA000001, 32'h12345678, 32'd0, 1'b0, 32'h00000004, 1'b0, 1'b0));
    q.push_back(mk("bneg",    32'hEAFFFFFF, 32'h12345678, 32'd0, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0));
    q.push_back(mk("pass",    32'hE8000000, 32'hCAFEF00D, 32'd0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0));
    foreach (q[i]) begin
      run32(q[i].ir, q[i].rm, q[i].rs, q[i].cin, o, c, e, lat);
      checks++;
      if (lat == 0) begin
        errors++; $display("FAIL %s timeout waiting for out_valid", q[i].name);
      end else begin
        checks++; if (o !== q[i].eo) begin errors++; $display("FAIL %s out got %h want %h", q[i].name, o, q[i].eo); end
        checks++; if (c !== q[i].ec) begin errors++; $display("FAIL %s cout got %b want %b", q[i].name, c, q[i].ec); end
        checks++; if (e !== q[i].ee) begin errors++; $display("FAIL %s err got %b want %b", q[i].name, e, q[i].ee); end
      end
    end
  endtask

  task automatic test_wide_branch();
    int lat;
    @(negedge clk);
    ir_w = 32'hEAFFFFFF; rm_w = 64'h0123456789ABCDEF; rs_w = 64'd0; c_in_w = 1'b1;
    out_ready_w = 1'b1; in_valid_w = 1'b1;
    @(negedge clk);
    in_valid_w = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      if (out_valid_w) begin lat = k; break; end
      @(negedge clk);
    end
    checks++;
    if (lat == 0) begin
      errors++; $display("FAIL wide_branch timeout waiting for out_valid");
    end else begin
      checks++; if (out_w !== 64'hFFFFFFFFFFFFFFFC) begin errors++; $display("FAIL wide_branch_out got %h want FFFFFFFFFFFFFFFC", out_w); end
      checks++; if ({shift_cout_w, err_w} !== 2'b10) begin errors++; $display("FAIL wide_branch_cout_err got %b want 10", {shift_cout_w, err_w}); end
    end
  endtask

  task automatic test_back_to_back();
    int acc; int got; logic rdy; logic ov; logic [31:0] ob;
    acc = 0; got = 0;
    out_ready = 1'b0; rm = 32'd0; rs = 32'd0; c_in = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      ir = 32'hE5900001 + 32'(acc); in_valid = 1'b1;
      rdy = in_ready;
      @(posedge clk);
      if (rdy) acc++;
    end
    checks++; if (acc !== 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", acc); end
    for (int h = 0; h < 2; h++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      checks++; if ({out_valid, out} !== {1'b1, 32'h00000001}) begin errors++; $display("FAIL bp_hold got %b/%h want 1/00000001", out_valid, out); end
    end
    for (int k = 0; k < 20 && got < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (acc < 3) begin in_valid = 1'b1; ir = 32'hE5900001 + 32'(acc); end
      else begin in_valid = 1'b0; end
      rdy = in_ready; ov = out_valid; ob = out;
      @(posedge clk);
      if (in_valid && rdy) acc++;
      if (ov) begin
        checks++; if (ob !== 32'(got + 1)) begin errors++; $display("FAIL bp_order got %h want %h", ob, 32'(got + 1)); end
        got++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (got !== 3) begin errors++; $display("FAIL bp_count got %0d want 3", got); end
  endtask

  task automatic test_reset_inflight();
    int seen; logic [31:0] o; logic c, e; int lat;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; ir = 32'hE5900007;
    @(negedge clk);
    ir = 32'hE5900008;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL rst_pre full got %b want 10", {out_valid, in_ready}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async out_valid got %b want 0", out_valid); end
    checks++; if (out !== 32'd0) begin errors++; $display("FAIL rst_async out got %h want 0", out); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_stale got %0d results want 0", seen); end
    run32(32'hE8000000, 32'h0BADBEEF, 32'd0, 1'b0, o, c, e, lat);
    checks++; if ({lat != 0, o} !== {1'b1, 32'h0BADBEEF}) begin errors++; $display("FAIL rst_recover got %h want 0BADBEEF", o); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ir = 32'd0; rm = 32'd0; rs = 32'd0; c_in = 1'b0;
    in_valid_w = 1'b0; out_ready_w = 1'b1; ir_w = 32'd0; rm_w = 64'd0; rs_w = 64'd0; c_in_w = 1'b0;
    test_reset();
    test_latency();
    test_imm_shift();
    test_reg_shift();
    test_modes();
    test_wide_branch();
    test_back_to_back();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter_operand_pipe.md
SHIFTER_OPERAND_PIPE -- requirements
Module: shifter_operand_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready at clk edge.
REQ-006 SHALL have port ir  input  32  instruction word; fields per ARM encoding.
REQ-007 SHALL have port rm  input  WIDTH  operand register value.
REQ-008 SHALL have port rs  input  WIDTH  shift-amount register value; only rs[7:0] used.
REQ-009 SHALL have port c_in  input  1  current carry flag.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready at clk edge.
REQ-012 SHALL have port out  output  WIDTH  shifter operand / offset result.
REQ-013 SHALL have port shift_cout  output  1  shifter carry-out.
REQ-014 SHALL have port err  output  1  result is for an unsupported encoding; valid with out_valid.

Function
REQ-015 SHALL be a two-stage pipeline: S1 registers ir, rm, rs[7:0], c_in; S2 registers out, shift_cout, err; latency exactly 2 cycles from acceptance to out_valid with no stall.
REQ-016 SHALL advance S2 when !out_valid || out_ready; S1 advances when S2 advances; in_ready = !S1_valid || S2 advances (full throughput, one result per cycle).
REQ-017 SHALL hold out, shift_cout, err stable while out_valid && !out_ready; no request dropped or duplicated.
REQ-018 SHALL decode ir[27:25]: 000 data-proc shift, 001 rotated immediate, 010 load/store immediate, 011 load/store scaled register, 101 branch, other = pass-through.
REQ-019 Mode 000, ir[4]=0, amount n=ir[11:7]: LSL n=0 -> rm, c_in; LSL n>0 -> rm<<n, rm[WIDTH-n].
REQ-020 Mode 000 immediate LSR: n=0 means WIDTH -> 0, rm[WIDTH-1]; n>0 -> rm>>n, rm[n-1].
REQ-021 Mode 000 immediate ASR: n=0 means WIDTH -> all bits rm[WIDTH-1], carry rm[WIDTH-1]; n>0 -> arithmetic shift, rm[n-1].
REQ-022 Mode 000 immediate ROR: n=0 is RRX -> {c_in, rm[WIDTH-1:1]}, rm[0]; n>0 -> rotate right n, rm[n-1].
REQ-023 Mode 000, ir[4]=1, ir[7]=0: register shift, a=rs[7:0]; a=0 -> rm, c_in for all types.
REQ-024 Register LSL: 1<=a<WIDTH -> rm<<a, rm[WIDTH-a]; a=WIDTH -> 0, rm[0]; a>WIDTH -> 0, 0.
REQ-025 Register LSR: 1<=a<WIDTH -> rm>>a, rm[a-1]; a=WIDTH -> 0, rm[WIDTH-1]; a>WIDTH -> 0, 0.
REQ-026 Register ASR: 1<=a<WIDTH as REQ-021; a>=WIDTH -> all sign bits, rm[WIDTH-1].
REQ-027 Register ROR: r=a mod WIDTH; r=0 (a>0) -> rm, rm[WIDTH-1]; else rotate r, rm[r-1].
REQ-028 Mode 000 with ir[4]=1 and ir[7]=1 SHALL output rm, c_in, err=1.
REQ-029 Mode 001: imm8 zero-extended to WIDTH, rotated right 2*ir[11:8]; carry c_in if ir[11:8]=0 else out[WIDTH-1].
REQ-030 Mode 010: out = zero-extended ir[11:0], carry c_in.
REQ-031 Mode 011: ir[4]=0 -> immediate shift of rm per REQ-019..022; ir[4]=1 -> rm, c_in, err=1.
REQ-032 Mode 101: out = sign-extended ir[23:0] shifted left 2 to WIDTH bits, carry c_in.
REQ-033 Pass-through modes SHALL output rm, c_in, err=0.

Reset
REQ-034 SHALL on rst_n=0 immediately clear S1/S2 valid, out=0, shift_cout=0, err=0, out_valid=0; in_ready=1 from first edge after release.
REQ-035 SHALL discard in-flight requests on reset; no result emitted for them after release.

Verification
REQ-036 WIDTH=32, ir=0xE1A00080 (LSL #1), rm=0x80000001, out_ready=1 -> 2 cycles later out=0x00000002, shift_cout=1.
REQ-037 Register LSR, rs=32, rm=0x80000000 -> out=0, shift_cout=1; rs=33 -> out=0, shift_cout=0; rs=0, c_in=1 -> out=rm, shift_cout=1.
REQ-038 Immediate ROR #0 (RRX), c_in=1, rm=0x00000003 -> out=0x80000001, shift_cout=1; mode 001 imm8=0xFF, rot=4 -> out=0xFF000000, shift_cout=1.
REQ-039 Branch ir[23:0]=0xFFFFFF, WIDTH=64 -> out=0xFFFFFFFFFFFFFFFC; out_ready=0 for 3 cycles with 3 requests -> in_ready drops after 2 accepted, results delivered in order unchanged.
REQ-040 Assert rst_n=0 with both stages valid -> out_valid=0 asynchronously; after release no stale result appears; err=1 for ir[27:25]=000, ir[7]=1, ir[4]=1.
